// File: rtl/system_top_strait_if.sv
// Host-side handshake of the STRAIT memory BIST: start request, mode, and status.
// The host drives the master modport; the BIST block uses the slave modport.
interface system_top_strait_if;
  logic       bist_en;
  logic [1:0] bist_mode;
  logic       done;
  logic       fail;

  modport master (output bist_en, output bist_mode, input done, input fail);
  modport slave  (input bist_en, input bist_mode, output done, output fail);
endinterface

// File: rtl/system_top_strait.sv
// STRAIT memory BIST: embedded single-port RAM plus MATS+ / March C- controller.
// Optional macro STRAIT_FAULT_INJECT_EN makes bit 0 of address 3 read stuck-at-0.
module system_top_strait #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  system_top_strait_if.slave   bus
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [3:0] SA_FIRST = 4'd0;
  localparam logic [3:0] SA_LAST  = 4'd2;
  localparam logic [3:0] TF_FIRST = 4'd3;
  localparam logic [3:0] TF_LAST  = 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic desc;
    logic two;
    logic rd0;
    logic v0;
    logic rd1;
    logic v1;
  } elem_t;

  // Elements 0..2 are MATS+, 3..8 are March C-, so mode 11 simply runs 0..8.
  function automatic elem_t elem_decode(input logic [3:0] idx);
    elem_t e;
    case (idx)
      4'd0:    e = '{desc: 1'b0, two: 1'b0, rd0: 1'b0, v0: 1'b0, rd1: 1'b0, v1: 1'b0};
      4'd1:    e = '{desc: 1'b0, two: 1'b1, rd0: 1'b1, v0: 1'b0, rd1: 1'b0, v1: 1'b1};
      4'd2:    e = '{desc: 1'b1, two: 1'b1, rd0: 1'b1, v0: 1'b1, rd1: 1'b0, v1: 1'b0};
      4'd3:    e = '{desc: 1'b0, two: 1'b0, rd0: 1'b0, v0: 1'b0, rd1: 1'b0, v1: 1'b0};
      4'd4:    e = '{desc: 1'b0, two: 1'b1, rd0: 1'b1, v0: 1'b0, rd1: 1'b0, v1: 1'b1};
      4'd5:    e = '{desc: 1'b0, two: 1'b1, rd0: 1'b1, v0: 1'b1, rd1: 1'b0, v1: 1'b0};
      4'd6:    e = '{desc: 1'b1, two: 1'b1, rd0: 1'b1, v0: 1'b0, rd1: 1'b0, v1: 1'b1};
      4'd7:    e = '{desc: 1'b1, two: 1'b1, rd0: 1'b1, v0: 1'b1, rd1: 1'b0, v1: 1'b0};
      4'd8:    e = '{desc: 1'b1, two: 1'b0, rd0: 1'b1, v0: 1'b0, rd1: 1'b0, v1: 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;
  logic              fail_q, fail_d;

  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  elem_t             cur, nxt;
  logic              op_rd, op_val;
  logic [3:0]        last_elem;

  always_comb begin
`ifdef STRAIT_FAULT_INJECT_EN
    rdata = mem_q[addr_q];
    if (addr_q == ADDR_W'(3)) rdata[0] = 1'b0;
`else
    rdata = mem_q[addr_q];
`endif
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    op_d      = op_q;
    fail_d    = fail_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    cur       = elem_decode(elem_q);
    nxt       = elem_decode(elem_q + 4'd1);
    op_rd     = op_q ? cur.rd1 : cur.rd0;
    op_val    = op_q ? cur.v1  : cur.v0;
    last_elem = (mode_q == 2'b01) ? SA_LAST : TF_LAST;

    case (state_q)
      IDLE, DONE: begin
        if (bus.bist_en) begin
          state_d = RUN;
          mode_d  = bus.bist_mode;
          fail_d  = 1'b0;
          elem_d  = (bus.bist_mode == 2'b10) ? TF_FIRST : SA_FIRST;
          addr_d  = ADDR_ZERO;
          op_d    = 1'b0;
        end
      end
      RUN: begin
        if (mode_q == 2'b00) begin
          state_d = DONE;
        end else begin
          if (op_rd) begin
            if (rdata != {DATA_W{op_val}}) fail_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = {DATA_W{op_val}};
          end
          if (cur.two && !op_q) begin
            op_d = 1'b1;
          end else begin
            op_d = 1'b0;
            // The last address of an element hands over to the next element's start address.
            if (addr_q == (cur.desc ? ADDR_ZERO : ADDR_MAX)) begin
              if (elem_q == last_elem) begin
                state_d = DONE;
              end else begin
                elem_d = elem_q + 4'd1;
                addr_d = nxt.desc ? ADDR_MAX : ADDR_ZERO;
              end
            end else begin
              addr_d = cur.desc ? (addr_q - 1'b1) : (addr_q + 1'b1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      elem_q  <= 4'd0;
      addr_q  <= ADDR_ZERO;
      op_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      fail_q  <= fail_d;
    end
  end

  // RAM contents are deliberately not reset; every algorithm starts with a write pass.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= mem_wdata;
  end

  assign bus.done = (state_q == DONE);
  assign bus.fail = fail_q;

endmodule

// File: tb/tb_system_top_strait.sv
// Directed bench for system_top_strait: latency of each mode, fail behaviour, reset and restart.
// Expectations follow STRAIT_FAULT_INJECT_EN when the bench is built with it.
module tb_system_top_strait;

`ifdef STRAIT_FAULT_INJECT_EN
  localparam int FAULTY   = 1;
  localparam int SA_FIRST = 73;
  localparam int TF_FIRST = 55;
`else
  localparam int FAULTY   = 0;
  localparam int SA_FIRST = 0;
  localparam int TF_FIRST = 0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   edges;
  int   first_fail;

  system_top_strait_if bif ();

  system_top_strait #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drives one start edge E0; returns 1 ns after E0 with bist_en dropped unless held.
  task automatic applyStimulus(input logic [1:0] mode, input logic hold);
    @(negedge clk);
    bif.bist_en   = 1'b1;
    bif.bist_mode = mode;
    @(posedge clk);
    #1;
    if (!hold) bif.bist_en = 1'b0;
  endtask

  task automatic waitDone(input int max_edges, output int n, output int ff);
    n  = 0;
    ff = 0;
    while (n < max_edges) begin
      @(posedge clk);
      #1;
      n++;
      if (bif.fail && ff == 0) ff = n;
      if (bif.done) break;
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    bif.bist_en   = 1'b0;
    bif.bist_mode = 2'b00;
    #12;
    checkOutput("reset_done", int'(bif.done), 0);
    checkOutput("reset_fail", int'(bif.fail), 0);
    #8 reset = 1'b1;

    applyStimulus(2'b01, 1'b0);
    checkOutput("sa_busy", int'(bif.done), 0);
    waitDone(400, edges, first_fail);
    checkOutput("sa_latency", edges, 80);
    checkOutput("sa_fail", int'(bif.fail), FAULTY);
    checkOutput("sa_first_fail", first_fail, SA_FIRST);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sa_done_hold", int'(bif.done), 1);

    applyStimulus(2'b10, 1'b0);
    checkOutput("tf_restart_drop", int'(bif.done), 0);
    waitDone(400, edges, first_fail);
    checkOutput("tf_latency", edges, 160);
    checkOutput("tf_fail", int'(bif.fail), FAULTY);
    checkOutput("tf_first_fail", first_fail, TF_FIRST);

    applyStimulus(2'b11, 1'b0);
    waitDone(400, edges, first_fail);
    checkOutput("both_latency", edges, 240);
    checkOutput("both_fail", int'(bif.fail), FAULTY);
    checkOutput("both_first_fail", first_fail, SA_FIRST);

    applyStimulus(2'b00, 1'b0);
    checkOutput("none_restart_drop", int'(bif.done), 0);
    checkOutput("none_fail_clear", int'(bif.fail), 0);
    waitDone(400, edges, first_fail);
    checkOutput("none_latency", edges, 1);
    checkOutput("none_fail", int'(bif.fail), 0);

    // Mid-run asynchronous reset, then a clean restart.
    applyStimulus(2'b01, 1'b0);
    repeat (40) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_done", int'(bif.done), 0);
    checkOutput("midreset_fail", int'(bif.fail), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b01, 1'b0);
    waitDone(400, edges, first_fail);
    checkOutput("after_reset_latency", edges, 80);
    checkOutput("after_reset_fail", int'(bif.fail), FAULTY);

    // bist_en held and mode toggled while running must not disturb the run.
    applyStimulus(2'b01, 1'b1);
    edges = 0;
    while (edges < 400) begin
      bif.bist_mode = edges[0] ? 2'b10 : 2'b11;
      @(posedge clk);
      #1;
      edges++;
      if (bif.done) break;
    end
    bif.bist_en = 1'b0;
    checkOutput("toggle_latency", edges, 80);
    checkOutput("toggle_fail", int'(bif.fail), FAULTY);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("toggle_done_hold", int'(bif.done), 1);

    applyStimulus(2'b10, 1'b0);
    checkOutput("restart_drop", int'(bif.done), 0);
    waitDone(400, edges, first_fail);
    checkOutput("restart_latency", edges, 160);
    checkOutput("restart_fail", int'(bif.fail), FAULTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
